seg7_scan_driver: RTL

Parametrised multi-digit seven-segment scan driver for the FPGA board top levels. It replaces the fixed single-digit mapping (one anode tied on, segments driven straight from the design outputs). It time-multiplexes `NUM_DIGITS` digits and decodes hex or passes raw segment bytes per digit. It blanks anodes at every digit change to suppress ghosting, and double-buffers display data so a frame is never torn. It sits between the user-project outputs and the board `seg`/`dp`/`an` pins.

---
 rtl/seg7_scan_driver.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Purpose : multi-digit seven-segment scan driver with hex/raw decode per digit,
//           anode blanking at slot start and double-buffered (tear-free) display data.
// Latency : seg/dp/an/frame_done are registered, 1 cycle behind the internal scan state;
//           loaded data appears on seg one cycle after the next frame boundary edge.
// Backpressure: none; load is always accepted, later loads overwrite the staging buffer.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   data[8*N-1:0]      byte i drives digit i
//   mode[N-1:0]        per digit: 1 = hex decode of low nibble (bit 7 = dp), 0 = raw {dp,seg}
//   load               capture data/mode into staging
//   pending            staging holds data not yet copied into the active buffer
//   frame_done         one-cycle pulse in the first cycle of a new frame
//   seg[6:0] (a..g), dp, an[N-1:0]  board pins, polarity set by parameters
//   brightness[3:0]    only when SEG7_BRIGHTNESS_EN is defined: anode lit only while p[3:0] <= brightness
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [8*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   mode,
    input  logic                    load,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]         P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [KW-1:0]         K_LAST  = KW'(NUM_DIGITS - 1);
    // Inactive (off) levels; XOR with these converts active-high to pin polarity.
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PW-1:0]           p_q, p_d;
    logic [KW-1:0]           k_q, k_d;
    logic [8*NUM_DIGITS-1:0] stg_data_q, stg_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   stg_mode_q, stg_mode_d, act_mode_q, act_mode_d;
    logic                    pending_q, pending_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    slot_end, wrap, lit, cur_mode, dp_raw;
    logic [7:0]              cur_byte;
    logic [6:0]              seg_raw;
    logic [NUM_DIGITS-1:0]   an_raw;

    always_comb begin
        slot_end = (p_q == P_LAST);
        wrap     = slot_end && (k_q == K_LAST);

        p_d = slot_end ? '0 : p_q + PW'(1);
        k_d = k_q;
        if (slot_end) begin
            k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
        end

        // The active buffer is copied from staging before the staging register
        // takes a same-cycle load, so a load in the wrap cycle waits one frame.
        act_data_d = act_data_q;
        act_mode_d = act_mode_q;
        if (wrap && pending_q) begin
            act_data_d = stg_data_q;
            act_mode_d = stg_mode_q;
        end

        stg_data_d = stg_data_q;
        stg_mode_d = stg_mode_q;
        pending_d  = pending_q;
        if (wrap) begin
            pending_d = 1'b0;
        end
        if (load) begin
            stg_data_d = data;
            stg_mode_d = mode;
            pending_d  = 1'b1;
        end

        frame_done_d = wrap;

        cur_byte = '0;
        cur_mode = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (k_q == KW'(i)) begin
                cur_byte = act_data_q[8*i +: 8];
                cur_mode = act_mode_q[i];
            end
        end

        if (cur_mode) begin
            seg_raw = hex_decode(cur_byte[3:0]);
            dp_raw  = cur_byte[7];
        end else begin
            seg_raw = cur_byte[6:0];
            dp_raw  = cur_byte[7];
        end

        // Anodes stay off for the first BLANK_CYCLES of each slot while seg settles.
        lit = (p_q >= P_BLANK);
`ifdef SEG7_BRIGHTNESS_EN
        lit = lit && (4'(p_q) <= brightness);
`endif

        an_raw = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_raw[i] = lit && (k_q == KW'(i));
        end

        seg_d = seg_raw ^ SEG_OFF;
        dp_d  = dp_raw ^ DP_OFF;
        an_d  = an_raw ^ AN_OFF;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_q          <= '0;
            k_q          <= '0;
            stg_data_q   <= '0;
            stg_mode_q   <= '0;
            act_data_q   <= '0;
            act_mode_q   <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            p_q          <= p_d;
            k_q          <= k_d;
            stg_data_q   <= stg_data_d;
            stg_mode_q   <= stg_mode_d;
            act_data_q   <= act_data_d;
            act_mode_q   <= act_mode_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;

endmodule
